// File: rtl/sram_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// sram_ctrl_pkg
// Shared constants and types for the initiator-side controller of the
// single-port 128x8 SRAM macro.
//   BITS          data width of the macro D/Q buses
//   WORD_DEPTH    number of macro words
//   ADD_WIDTH     macro address width, log2(WORD_DEPTH)
//   BUF_DEPTH_MIN smallest response buffer that sustains one read per cycle
//   req_t         request bundle (write, addr, wdata)
//   buf_depth_ok  static legality check for a response buffer depth
// ---------------------------------------------------------------------------
package sram_ctrl_pkg;

   localparam int BITS          = 8;
   localparam int WORD_DEPTH    = 128;
   localparam int ADD_WIDTH     = 7;
   localparam int BUF_DEPTH_MIN = 2;

   typedef struct packed {
      logic                 write;
      logic [ADD_WIDTH-1:0] addr;
      logic [BITS-1:0]      wdata;
   } req_t;

   // One slot covers the read in flight, the second covers the read fired
   // in the same cycle the consumer first stalls.  Fewer than two slots
   // cannot sustain back-to-back reads.
   function automatic bit buf_depth_ok(input int depth);
      return depth >= BUF_DEPTH_MIN;
   endfunction

   localparam bit ADD_WIDTH_OK = (ADD_WIDTH == $clog2(WORD_DEPTH));

endpackage

// File: rtl/sram_resp_fifo.sv
// ---------------------------------------------------------------------------
// sram_resp_fifo
// Small synchronous FIFO that parks read data the consumer has not yet taken.
// Ports:
//   CLK    clock
//   RSTB   asynchronous active-low reset; empties the FIFO and zeroes storage
//   push   write wdata at the tail this cycle
//   pop    drop the head entry this cycle (ignored when empty)
//   wdata  data to push
//   occ    number of valid entries, 0..DEPTH
//   head   oldest entry; zero-filled storage keeps it free of X after reset
// ---------------------------------------------------------------------------
module sram_resp_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic                       CLK,
   input  logic                       RSTB,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           wdata,
   output logic [$clog2(DEPTH+1)-1:0] occ,
   output logic [WIDTH-1:0]           head
);

   localparam int OCC_W = $clog2(DEPTH + 1);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && (occ != OCC_W'(DEPTH));
   assign do_pop  = pop && (occ != '0);
   assign head    = mem[rd_ptr];

   // Explicit wrap so non-power-of-two depths work as well.
   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge CLK or negedge RSTB) begin
      if (!RSTB) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= ptr_next(wr_ptr);
         end
         if (do_pop) rd_ptr <= ptr_next(rd_ptr);
         case ({do_push, do_pop})
            2'b10:   occ <= occ + 1'b1;
            2'b01:   occ <= occ - 1'b1;
            default: occ <= occ;
         endcase
      end
   end

   // Credit accounting upstream must make a push into a full FIFO impossible.
   overflow_check: assert property (@(posedge CLK) disable iff (!RSTB)
      !(push && occ == OCC_W'(DEPTH)));

endmodule

// File: rtl/sram_port_ctrl.sv
// ---------------------------------------------------------------------------
// sram_port_ctrl
// Initiator-side controller for the single-port 128x8 SRAM macro.  Turns a
// request channel into macro strobes and returns read data on a response
// channel with backpressure.  Read data is captured from Q exactly one cycle
// after the read fires, so nothing is lost while the consumer stalls.
//
// Handshake: a channel transfers on a cycle where valid && ready are both 1.
// Once valid is raised it and its payload hold until that transfer.  ready
// is a pure function of registered state and never looks at the partner's
// valid; the consumer's resp_ready may be anything at any time.
//
// Ports:
//   CLK, RSTB                 clock (also the macro clock), async active-low reset
//   req_valid/req_ready       request handshake
//   req_write/req_addr/req_wdata  request payload (1=write)
//   resp_valid/resp_ready     response handshake (reads only)
//   resp_rdata                read data, zero when nothing is pending
//   CEB/WEB/A/D               macro strobes, combinational from the request
//   Q                         macro read data, valid only the cycle after a read
// ---------------------------------------------------------------------------
module sram_port_ctrl
   import sram_ctrl_pkg::*;
#(
   parameter int BUF_DEPTH = 2
) (
   input  logic                 CLK,
   input  logic                 RSTB,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_write,
   input  logic [ADD_WIDTH-1:0] req_addr,
   input  logic [BITS-1:0]      req_wdata,
   output logic                 resp_valid,
   input  logic                 resp_ready,
   output logic [BITS-1:0]      resp_rdata,
   output logic                 CEB,
   output logic                 WEB,
   output logic [ADD_WIDTH-1:0] A,
   output logic [BITS-1:0]      D,
   input  logic [BITS-1:0]      Q
);

   localparam int OCC_W = $clog2(BUF_DEPTH + 1);

   if (!buf_depth_ok(BUF_DEPTH)) begin : g_bad_depth
      $error("sram_port_ctrl: BUF_DEPTH must be at least %0d", BUF_DEPTH_MIN);
   end
   if (!ADD_WIDTH_OK) begin : g_bad_width
      $error("sram_port_ctrl: ADD_WIDTH must equal log2(WORD_DEPTH)");
   end

   req_t             req;
   logic             fire;
   logic             inflight;
   logic [OCC_W-1:0] occ;
   logic [BITS-1:0]  fifo_head;
   logic             occ_zero;
   logic             push;
   logic             pop;

   assign req = '{write: req_write, addr: req_addr, wdata: req_wdata};

   // Credits: a buffered entry or a read still on its way to Q each hold one
   // slot, so a read is only accepted when it is guaranteed a landing place.
   assign req_ready = (int'(occ) + int'(inflight)) < BUF_DEPTH;
   assign fire      = req_valid && req_ready;

   // Macro strobes.  CEB is gated by RSTB so nothing is written while reset
   // is asserted even though req_ready is already 1.
   assign CEB = !(fire && RSTB);
   assign WEB = !req.write;
   assign A   = req.addr;
   assign D   = req.wdata;

   // inflight marks the single cycle in which Q carries real read data.
   always_ff @(posedge CLK or negedge RSTB) begin
      if (!RSTB) inflight <= 1'b0;
      else       inflight <= fire && !req.write;
   end

   assign occ_zero = (occ == '0);

   // With an empty buffer Q goes straight to the consumer; it is parked only
   // if the consumer stalls.  With data already buffered, Q must queue behind
   // it to keep request order.
   assign push = inflight && (!occ_zero || !resp_ready);
   assign pop  = !occ_zero && resp_ready;

   always_comb begin
      resp_valid = inflight || !occ_zero;
      resp_rdata = '0;
      if (!occ_zero)    resp_rdata = fifo_head;
      else if (inflight) resp_rdata = Q;
   end

   sram_resp_fifo #(
      .WIDTH (BITS),
      .DEPTH (BUF_DEPTH)
   ) u_resp_fifo (
      .CLK   (CLK),
      .RSTB  (RSTB),
      .push  (push),
      .pop   (pop),
      .wdata (Q),
      .occ   (occ),
      .head  (fifo_head)
   );

endmodule

// File: tb/tb_sram_port_ctrl.sv
module tb_sram_port_ctrl;

   logic       CLK = 1'b0;
   logic       RSTB;
   logic       req_valid, req_write, resp_ready;
   logic [6:0] req_addr;
   logic [7:0] req_wdata;
   logic       req_ready, resp_valid, CEB, WEB;
   logic [7:0] resp_rdata, D, Q;
   logic [6:0] A;

   int checks = 0;
   int errors = 0;

   logic [7:0] exp_q[$];
   logic [7:0] ref_mem [128];

   // ---------------- clock / reset ----------------
   always #5 CLK = ~CLK;

   // ---------------- macro model ----------------
   logic [7:0] macro_mem [128];
   logic [7:0] q_reg   = 8'h00;
   logic [7:0] garbage = 8'hE7;
   logic       q_valid = 1'b0;

   always @(posedge CLK) begin
      garbage <= 8'($urandom);
      q_valid <= (CEB === 1'b0) && (WEB === 1'b1);
      if (CEB === 1'b0) begin
         if (WEB === 1'b0) macro_mem[A] <= D;
         else              q_reg <= macro_mem[A];
      end
   end
   // Q carries random data on every cycle that does not follow a read.
   assign Q = q_valid ? q_reg : garbage;

   sram_port_ctrl dut (
      .CLK(CLK), .RSTB(RSTB),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
      .CEB(CEB), .WEB(WEB), .A(A), .D(D), .Q(Q)
   );

   // ---------------- driver ----------------
   task automatic drive(input logic v, input logic w, input logic [6:0] a,
                        input logic [7:0] d, input logic rr);
      @(negedge CLK);
      req_valid  = v;
      req_write  = w;
      req_addr   = a;
      req_wdata  = d;
      resp_ready = rr;
      #1;
      if (v && req_ready && RSTB && w) ref_mem[a] = d;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset;
      RSTB = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b1, 7'h05, 8'hEE, 1'b1);
         checks++; if (CEB !== 1'b1) begin errors++; $display("FAIL reset_ceb_in_reset got=%b exp=1", CEB); end
         checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid_in_reset got=%b exp=0", resp_valid); end
      end
      @(negedge CLK); RSTB = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b0, 7'h00, 8'h00, 1'b1);
         checks++; if (CEB !== 1'b1) begin errors++; $display("FAIL idle_ceb cyc=%0d got=%b exp=1", i, CEB); end
         checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL idle_req_ready cyc=%0d got=%b exp=1", i, req_ready); end
         checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL idle_resp_valid cyc=%0d got=%b exp=0", i, resp_valid); end
         checks++; if (resp_rdata !== 8'h00) begin errors++; $display("FAIL idle_resp_rdata cyc=%0d got=%h exp=00", i, resp_rdata); end
      end
   endtask

   task automatic test_write_read;
      drive(1'b1, 1'b1, 7'h03, 8'h5A, 1'b1);
      checks++; if ({req_ready, CEB, WEB} !== 3'b100) begin errors++; $display("FAIL wr_strobes got=%b exp=100", {req_ready, CEB, WEB}); end
      checks++; if ({A, D} !== {7'h03, 8'h5A}) begin errors++; $display("FAIL wr_addr_data got=%h/%h exp=03/5a", A, D); end
      drive(1'b1, 1'b0, 7'h03, 8'h00, 1'b1);
      checks++; if ({CEB, WEB} !== 2'b01) begin errors++; $display("FAIL rd_strobes got=%b exp=01", {CEB, WEB}); end
      checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL write_no_resp got=%b exp=0", resp_valid); end
      drive(1'b0, 1'b0, 7'h00, 8'h00, 1'b1);
      checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL raw_resp_valid got=%b exp=1", resp_valid); end
      checks++; if (resp_rdata !== 8'h5A) begin errors++; $display("FAIL raw_rdata got=%h exp=5a", resp_rdata); end
      drive(1'b0, 1'b0, 7'h00, 8'h00, 1'b1);
      checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL raw_after got=%b exp=0", resp_valid); end
   endtask

   task automatic test_stream;
      logic [7:0] e;
      int         n_resp;
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, 1'b1, 7'(i), 8'(i) ^ 8'hFF, 1'b1);
         checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL preload_ready i=%0d got=%b exp=1", i, req_ready); end
      end
      exp_q.delete();
      n_resp = 0;
      for (int i = 0; i < 18; i++) begin
         if (i < 16) drive(1'b1, 1'b0, 7'(i), 8'h00, 1'b1);
         else        drive(1'b0, 1'b0, 7'h00, 8'h00, 1'b1);
         if (i < 16) begin
            checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL stream_ready i=%0d got=%b exp=1", i, req_ready); end
         end
         if (i >= 1 && i <= 16) begin
            checks++;
            if (resp_valid !== 1'b1) begin errors++; $display("FAIL stream_valid i=%0d got=%b exp=1", i, resp_valid); end
            else begin
               e = exp_q.pop_front();
               n_resp++;
               if (resp_rdata !== e) begin errors++; $display("FAIL stream_data i=%0d got=%h exp=%h", i, resp_rdata, e); end
            end
         end else begin
            checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL stream_edge_valid i=%0d got=%b exp=0", i, resp_valid); end
         end
         if (i < 16) exp_q.push_back(8'(i) ^ 8'hFF);
      end
      checks++; if (n_resp != 16) begin errors++; $display("FAIL stream_count got=%0d exp=16", n_resp); end
   endtask

   task automatic test_back_pressure;
      drive(1'b1, 1'b1, 7'h10, 8'hA0, 1'b1);
      drive(1'b1, 1'b1, 7'h11, 8'hA1, 1'b1);
      drive(1'b1, 1'b1, 7'h12, 8'hA2, 1'b1);
      drive(1'b1, 1'b0, 7'h10, 8'h00, 1'b0);
      checks++; if ({req_ready, resp_valid} !== 2'b10) begin errors++; $display("FAIL bp_c0 rdy/vld got=%b exp=10", {req_ready, resp_valid}); end
      drive(1'b1, 1'b0, 7'h11, 8'h00, 1'b0);
      checks++; if ({req_ready, resp_valid, resp_rdata} !== {2'b11, 8'hA0}) begin errors++; $display("FAIL bp_c1 got=%b/%h exp=11/a0", {req_ready, resp_valid}, resp_rdata); end
      drive(1'b1, 1'b0, 7'h12, 8'h00, 1'b0);
      checks++; if ({req_ready, CEB} !== 2'b01) begin errors++; $display("FAIL bp_c2_stall rdy/ceb got=%b exp=01", {req_ready, CEB}); end
      checks++; if ({resp_valid, resp_rdata} !== {1'b1, 8'hA0}) begin errors++; $display("FAIL bp_c2_hold got=%b/%h exp=1/a0", resp_valid, resp_rdata); end
      drive(1'b1, 1'b0, 7'h12, 8'h00, 1'b0);
      checks++; if ({req_ready, resp_valid, resp_rdata} !== {2'b01, 8'hA0}) begin errors++; $display("FAIL bp_c3 got=%b/%h exp=01/a0", {req_ready, resp_valid}, resp_rdata); end
      drive(1'b1, 1'b0, 7'h12, 8'h00, 1'b1);
      checks++; if ({req_ready, resp_valid, resp_rdata} !== {2'b01, 8'hA0}) begin errors++; $display("FAIL bp_c4 got=%b/%h exp=01/a0", {req_ready, resp_valid}, resp_rdata); end
      drive(1'b1, 1'b0, 7'h12, 8'h00, 1'b1);
      checks++; if ({req_ready, CEB, resp_valid, resp_rdata} !== {3'b101, 8'hA1}) begin errors++; $display("FAIL bp_c5 got=%b/%h exp=101/a1", {req_ready, CEB, resp_valid}, resp_rdata); end
      drive(1'b0, 1'b0, 7'h00, 8'h00, 1'b1);
      checks++; if ({resp_valid, resp_rdata} !== {1'b1, 8'hA2}) begin errors++; $display("FAIL bp_c6 got=%b/%h exp=1/a2", resp_valid, resp_rdata); end
      drive(1'b0, 1'b0, 7'h00, 8'h00, 1'b1);
      checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL bp_c7 got=%b exp=0", resp_valid); end
   endtask

   task automatic test_garbage;
      logic       v, w, rr;
      logic [6:0] a;
      logic [7:0] d;
      for (int i = 0; i < 20; i++) begin
         drive(1'b0, 1'($urandom_range(0, 1)), 7'($urandom_range(0, 127)), 8'($urandom), 1'($urandom_range(0, 1)));
         checks++; if ({resp_valid, resp_rdata} !== 9'h000) begin errors++; $display("FAIL garbage_idle i=%0d got=%b/%h exp=0/00", i, resp_valid, resp_rdata); end
      end
      exp_q.delete();
      for (int i = 0; i < 100; i++) begin
         v  = (i < 90) ? 1'($urandom_range(0, 3) != 0) : 1'b0;
         w  = 1'($urandom_range(0, 2) == 0);
         a  = 7'($urandom_range(0, 31));
         d  = 8'($urandom);
         rr = (i < 90) ? 1'($urandom_range(0, 2) != 0) : 1'b1;
         drive(v, w, a, d, rr);
         checks++;
         if (resp_valid !== (exp_q.size() != 0)) begin
            errors++; $display("FAIL mix_valid i=%0d got=%b exp=%b", i, resp_valid, exp_q.size() != 0);
         end else if (resp_valid && resp_ready) begin
            if (resp_rdata !== exp_q[0]) begin errors++; $display("FAIL mix_data i=%0d got=%h exp=%h", i, resp_rdata, exp_q[0]); end
            void'(exp_q.pop_front());
         end
         if (req_valid && req_ready && !req_write) exp_q.push_back(ref_mem[req_addr]);
      end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL mix_drain left=%0d exp=0", exp_q.size()); end
   endtask

   task automatic test_reset_mid;
      drive(1'b1, 1'b0, 7'h20, 8'h00, 1'b0);
      drive(1'b1, 1'b0, 7'h21, 8'h00, 1'b0);
      @(negedge CLK);
      checks++; if ({req_ready, resp_valid} !== 2'b01) begin errors++; $display("FAIL rmid_loaded rdy/vld got=%b exp=01", {req_ready, resp_valid}); end
      RSTB = 1'b0;
      #1;
      checks++; if ({resp_valid, req_ready, CEB} !== 3'b011) begin errors++; $display("FAIL rmid_in_reset vld/rdy/ceb got=%b exp=011", {resp_valid, req_ready, CEB}); end
      checks++; if (resp_rdata !== 8'h00) begin errors++; $display("FAIL rmid_rdata got=%h exp=00", resp_rdata); end
      drive(1'b0, 1'b0, 7'h00, 8'h00, 1'b1);
      @(negedge CLK); RSTB = 1'b1;
      for (int i = 0; i < 6; i++) begin
         drive(1'b0, 1'b0, 7'h00, 8'h00, 1'b1);
         checks++; if ({resp_valid, req_ready, resp_rdata} !== {2'b01, 8'h00}) begin errors++; $display("FAIL rmid_stale i=%0d got=%b/%h exp=01/00", i, {resp_valid, req_ready}, resp_rdata); end
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      RSTB = 1'b0; req_valid = 1'b0; req_write = 1'b0;
      req_addr = '0; req_wdata = '0; resp_ready = 1'b1;
      for (int i = 0; i < 128; i++) begin
         macro_mem[i] = 8'(i) ^ 8'h33;
         ref_mem[i]   = 8'(i) ^ 8'h33;
      end
      test_reset();
      test_write_read();
      test_stream();
      test_back_pressure();
      test_garbage();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
